// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } divState_t;

endpackage

// File: rtl/rc_sub.sv
// Ripple-carry subtractor (A - B) built from full-adder cells: B is inverted
// and the carry chain starts at 1, so the final carry-out means "no borrow".
module fullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

module rc_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_noBorrow
);

  logic [N:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    fullAdder u_fa (
      .i_a    (i_a[i]),
      .i_b    (~i_b[i]),
      .i_cin  (w_carry[i]),
      .o_sum  (o_diff[i]),
      .o_cout (w_carry[i+1])
    );
  end

  assign o_noBorrow = w_carry[N];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH steps per
// division, with a short-circuit path for a zero divisor.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  divState_t        r_state;
  divState_t        w_nextState;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [CW-1:0]    r_cnt;
  logic             r_zeroPend;
  logic             r_dbz;

  logic             w_accept;
  logic             w_lastStep;
  logic             w_noBorrow;
  logic             w_qBit;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_remNext;

  // A zero-divisor request spends one cycle pending in IDLE before FIN;
  // no new start is taken while it is pending.
  assign w_accept   = (r_state == IDLE) && !r_zeroPend && start;
  assign w_lastStep = (r_cnt == LAST_STEP);

  assign w_shift = {r_rem, r_dvd[WIDTH-1]};

  rc_sub #(.N(WIDTH + 1)) u_sub (
    .i_a        (w_shift),
    .i_b        ({1'b0, r_dvs}),
    .o_diff     (w_diff),
    .o_noBorrow (w_noBorrow)
  );

  // The partial remainder stays below the divisor, so a successful trial
  // never sets the top difference bit.
  assign w_qBit    = w_noBorrow & ~w_diff[WIDTH];
  assign w_remNext = w_qBit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (r_zeroPend) begin
          w_nextState = FIN;
        end else if (w_accept && (divisor != '0)) begin
          w_nextState = CALC;
        end
      end
      CALC: begin
        if (w_lastStep) begin
          w_nextState = FIN;
        end
      end
      FIN:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_zeroPend  <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dvd <= dividend;
        r_dvs <= divisor;
        r_rem <= '0;
        r_cnt <= '0;
        if (divisor == '0) begin
          r_zeroPend <= 1'b1;
        end else begin
          r_dbz <= 1'b0;
        end
      end
      if (r_zeroPend) begin
        r_zeroPend  <= 1'b0;
        r_quotient  <= '1;
        r_remainder <= r_dvd;
        r_dbz       <= 1'b1;
      end
      // The dividend register doubles as the quotient shift register.
      if (r_state == CALC) begin
        r_rem <= w_remNext;
        r_dvd <= {r_dvd[WIDTH-2:0], w_qBit};
        r_cnt <= r_cnt + 1'b1;
        if (w_lastStep) begin
          r_quotient  <= {r_dvd[WIDTH-2:0], w_qBit};
          r_remainder <= w_remNext;
        end
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state == CALC);
  assign done        = (r_state == FIN);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: a driver queues expected results from
// plain integer division, a negedge monitor checks each done pulse.
module tb_seq_divider;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           cyc;
  } exp_t;

  logic         hz100;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edgeCnt = 0;
  logic prevDone = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .hz100       (hz100),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  always @(posedge hz100) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT idle; the next rising edge accepts.
  task automatic applyStimulus(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    exp_t e;
    int   lat;
    if (dvs == 0) begin
      e.q = 8'd255;
      e.r = dvd;
      e.z = 1'b1;
      lat = 1;
    end else begin
      e.q = W'(int'(dvd) / int'(dvs));
      e.r = W'(int'(dvd) % int'(dvs));
      e.z = 1'b0;
      lat = W;
    end
    e.cyc = edgeCnt + 1 + lat;
    sb.push_back(e);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(negedge hz100);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic waitDone(input int expBusy, input string tag);
    int busyCnt = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy) busyCnt++;
      if (done) seen = 1'b1;
      else @(negedge hz100);
    end
    checkOutput({tag, "_doneSeen"}, int'(seen), 1);
    checkOutput({tag, "_busyCycles"}, busyCnt, expBusy);
    @(negedge hz100);
  endtask

  always @(negedge hz100) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", int'(quotient), int'(e.q));
        checkOutput("remainder", int'(remainder), int'(e.r));
        checkOutput("divByZero", int'(div_by_zero), int'(e.z));
        checkOutput("doneLatency", edgeCnt, e.cyc);
      end
      if (prevDone) checkOutput("donePulseWidth", 2, 1);
    end
    prevDone = done;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] rDvd;
    logic [W-1:0] rDvs;
    int sel;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge hz100);
    checkOutput("rst_quotient", int'(quotient), 0);
    checkOutput("rst_remainder", int'(remainder), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_dbz", int'(div_by_zero), 0);
    reset = 1'b0;

    // First start right after reset release, then the directed cases.
    applyStimulus(8'd100, 8'd7);   waitDone(8, "d100_7");
    applyStimulus(8'd255, 8'd1);   waitDone(8, "d255_1");
    applyStimulus(8'd5, 8'd9);     waitDone(8, "d5_9");
    applyStimulus(8'd42, 8'd0);    waitDone(0, "d42_0");
    applyStimulus(8'd9, 8'd3);     waitDone(8, "d9_3");
    applyStimulus(8'd0, 8'd13);    waitDone(8, "d0_13");
    applyStimulus(8'd255, 8'd255); waitDone(8, "d255_255");
    applyStimulus(8'd0, 8'd0);     waitDone(0, "d0_0");

    // A start during CALC must be ignored.
    applyStimulus(8'd100, 8'd7);
    repeat (2) @(negedge hz100);
    dividend = 8'd200;
    divisor  = 8'd10;
    start    = 1'b1;
    @(negedge hz100);
    start    = 1'b0;
    waitDone(5, "ignoredStart");
    repeat (3) @(negedge hz100);

    // Reset in the middle of CALC aborts the operation.
    applyStimulus(8'd100, 8'd7);
    repeat (3) @(negedge hz100);
    reset = 1'b1;
    #1;
    sb.delete();
    checkOutput("midRst_quotient", int'(quotient), 0);
    checkOutput("midRst_remainder", int'(remainder), 0);
    checkOutput("midRst_busy", int'(busy), 0);
    checkOutput("midRst_done", int'(done), 0);
    checkOutput("midRst_dbz", int'(div_by_zero), 0);
    @(negedge hz100);
    reset = 1'b0;
    applyStimulus(8'd60, 8'd8);    waitDone(8, "d60_8");

    for (int n = 0; n < 2000; n++) begin
      rDvd = W'($urandom_range(0, 255));
      sel  = $urandom_range(0, 9);
      if (sel == 0)     rDvs = '0;
      else if (sel < 4) rDvs = W'($urandom_range(1, 15));
      else              rDvs = W'($urandom_range(1, 255));
      applyStimulus(rDvd, rDvs);
      waitDone((rDvs == 0) ? 0 : W, "rand");
    end

    repeat (4) @(negedge hz100);
    checkOutput("scoreboardDrained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
